mc_control_unit: RTL and testbench

//  Multi-cycle MIPS control FSM; the issuing end of the ALU func/Z_flag interface.

---
 rtl/ctrl_pkg.sv | 68 ++++++
 rtl/alu_func_decode.sv | 49 ++++
 rtl/mc_control_unit.sv | 187 ++++++++++++++++++
 tb/tb_mc_control_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, ALU func codes,
// instruction classes and FSM states (TRAP exists only with CTRL_ILLEGAL_TRAP_EN).
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_BLEZ  = 6'b110110;
  localparam logic [5:0] FN_BGTZ  = 6'b110010;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_R,
    CLS_I,
    CLS_MEM,
    CLS_BR,
    CLS_J
  } op_class_t;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_WB_ALU,
    S_MEM_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP
`ifdef CTRL_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  // R-type functs the datapath ALU implements (shifts, add/sub, logic, set-less-than).
  function automatic logic r_funct_legal(input logic [5:0] fn);
    case (fn)
      6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
      FN_ADD, FN_ADDU, FN_SUB, 6'b100011, FN_AND, FN_OR, FN_XOR, 6'b100111,
      FN_SLT, FN_SLTU: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_func_decode.sv
// Combinational opcode/funct decode to ALU func code, operand-B select, immediate
// extension mode, legality and instruction class.
module alu_func_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [5:0] alu_func,
  output logic       alu_src_b,
  output logic       zero_ext,
  output logic       legal,
  output op_class_t  op_class
);

  always_comb begin
    alu_func  = FN_ADDU;
    alu_src_b = 1'b0;
    zero_ext  = 1'b0;
    legal     = 1'b1;
    op_class  = CLS_NONE;
    case (opcode)
      OP_RTYPE: begin
        alu_func = funct;
        legal    = r_funct_legal(funct);
        op_class = legal ? CLS_R : CLS_NONE;
      end
      OP_ADDI:  begin alu_func = FN_ADD;  alu_src_b = 1'b1; op_class = CLS_I; end
      OP_ADDIU: begin alu_func = FN_ADDU; alu_src_b = 1'b1; op_class = CLS_I; end
      OP_SLTI:  begin alu_func = FN_SLT;  alu_src_b = 1'b1; op_class = CLS_I; end
      OP_SLTIU: begin alu_func = FN_SLTU; alu_src_b = 1'b1; op_class = CLS_I; end
      OP_ANDI: begin
        alu_func = FN_AND; alu_src_b = 1'b1; zero_ext = 1'b1; op_class = CLS_I;
      end
      OP_ORI: begin
        alu_func = FN_OR;  alu_src_b = 1'b1; zero_ext = 1'b1; op_class = CLS_I;
      end
      OP_XORI: begin
        alu_func = FN_XOR; alu_src_b = 1'b1; zero_ext = 1'b1; op_class = CLS_I;
      end
      OP_LW, OP_SW: begin alu_func = FN_ADDU; alu_src_b = 1'b1; op_class = CLS_MEM; end
      OP_BEQ, OP_BNE: begin alu_func = FN_SUB; op_class = CLS_BR; end
      OP_BLEZ:  begin alu_func = FN_BLEZ; op_class = CLS_BR; end
      OP_BGTZ:  begin alu_func = FN_BGTZ; op_class = CLS_BR; end
      OP_J:     op_class = CLS_J;
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM driving ALU func and datapath strobes.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (undecodable instruction -> TRAP).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FETCH     | read instruction; on mem_ready latch IR and PC+4
// DECODE    | route by opcode class
// EXEC_R    | R-type ALU op, operand B = rt
// EXEC_I    | immediate ALU op, operand B = extended immediate
// WB_ALU    | write ALU result (rd for R-type, rt for immediate)
// MEM_ADDR  | effective address = rs + sign-extended offset
// MEM_RD    | load request held until mem_ready or timeout
// WB_MEM    | write load data to rt
// MEM_WR    | store request held until mem_ready or timeout
// BRANCH    | compare via ALU, take branch from z_flag
// JUMP      | PC <- jump target
// TRAP      | illegal instruction, frozen until reset (trap build only)
module mc_control_unit
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        z_flag,
  input  logic        mem_ready,
  output logic [5:0]  alu_func,
  output logic        alu_src_b,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        mem_timeout,
  output logic        illegal
);

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [5:0]       dec_func;
  logic             dec_src_b, dec_zero_ext, dec_legal;
  op_class_t        op_class;
  logic             mem_state, stall, limit, branch_taken;
  logic             unused_bits;

  alu_func_decode u_dec (
    .opcode    (instr[31:26]),
    .funct     (instr[5:0]),
    .alu_func  (dec_func),
    .alu_src_b (dec_src_b),
    .zero_ext  (dec_zero_ext),
    .legal     (dec_legal),
    .op_class  (op_class)
  );

  // Immediate extension and register fields are handled in the datapath.
  assign unused_bits = ^{instr[25:6], dec_zero_ext};

  assign mem_state    = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign stall        = mem_state && !mem_ready;
  assign limit        = stall && (wait_cnt == CNT_W'(MEM_WAIT_MAX - 1));
  assign branch_taken = (instr[31:26] == OP_BNE) ? !z_flag : z_flag;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset || state_next != state || limit) wait_cnt <= '0;
    else if (stall)                            wait_cnt <= wait_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)      mem_timeout <= 1'b0;
    else if (limit) mem_timeout <= 1'b1;
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal = (state == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

  // Reset masks the decoded strobes so an access in flight is dropped immediately.
  always_comb begin
    state_next = state;
    alu_func   = FN_ADDU;
    alu_src_b  = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    if (reset) begin
      state_next = S_FETCH;
    end else begin
      case (state)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = S_DECODE;
          end
        end
        S_DECODE: begin
          if (!dec_legal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_next = S_TRAP;
`else
            state_next = S_FETCH;
`endif
          end else begin
            case (op_class)
              CLS_R:   state_next = S_EXEC_R;
              CLS_I:   state_next = S_EXEC_I;
              CLS_MEM: state_next = S_MEM_ADDR;
              CLS_BR:  state_next = S_BRANCH;
              CLS_J:   state_next = S_JUMP;
              default: state_next = S_FETCH;
            endcase
          end
        end
        S_EXEC_R: begin
          alu_func   = dec_func;
          state_next = S_WB_ALU;
        end
        S_EXEC_I: begin
          alu_func   = dec_func;
          alu_src_b  = dec_src_b;
          state_next = S_WB_ALU;
        end
        S_WB_ALU: begin
          reg_write  = 1'b1;
          reg_dst    = (op_class == CLS_R);
          state_next = S_FETCH;
        end
        S_MEM_ADDR: begin
          alu_func   = dec_func;
          alu_src_b  = dec_src_b;
          state_next = (instr[31:26] == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          if (mem_ready)  state_next = S_WB_MEM;
          else if (limit) state_next = S_FETCH;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          state_next = S_FETCH;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          if (mem_ready || limit) state_next = S_FETCH;
        end
        S_BRANCH: begin
          alu_func = dec_func;
          if (branch_taken) begin
            pc_write = 1'b1;
            pc_src   = 2'b01;
          end
          state_next = S_FETCH;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          state_next = S_FETCH;
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        S_TRAP: state_next = S_TRAP;
`endif
        default: state_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit; strobes are compared as one packed vector.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        reset, z_flag, mem_ready;
  logic [31:0] instr;
  logic [5:0]  alu_func;
  logic        alu_src_b, reg_dst, reg_write, mem_to_reg, mem_read, mem_write;
  logic        ir_write, pc_write, mem_timeout, illegal;
  logic [1:0]  pc_src;

  int total = 0;
  int bad   = 0;

  // {mem_read, mem_write, ir_write, pc_write, pc_src[1:0], reg_write, reg_dst, mem_to_reg, alu_src_b}
  wire [9:0] strb = {mem_read, mem_write, ir_write, pc_write, pc_src,
                     reg_write, reg_dst, mem_to_reg, alu_src_b};

  localparam logic [9:0] V_IDLE   = 10'b0000000000;
  localparam logic [9:0] V_FETCH  = 10'b1011000000;
  localparam logic [9:0] V_RD     = 10'b1000000000;
  localparam logic [9:0] V_WR     = 10'b0100000000;
  localparam logic [9:0] V_IMM    = 10'b0000000001;
  localparam logic [9:0] V_WB_R   = 10'b0000001100;
  localparam logic [9:0] V_WB_I   = 10'b0000001000;
  localparam logic [9:0] V_WB_MEM = 10'b0000001010;
  localparam logic [9:0] V_BR_T   = 10'b0001010000;
  localparam logic [9:0] V_JMP    = 10'b0001100000;
  localparam logic [5:0] F_ADDU   = 6'b100001;

  mc_control_unit dut (
    .clk(clk), .reset(reset), .instr(instr), .z_flag(z_flag), .mem_ready(mem_ready),
    .alu_func(alu_func), .alu_src_b(alu_src_b), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .mem_timeout(mem_timeout), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // FETCH with zero-wait memory, then the DECODE cycle.
  task automatic fetch_decode(input logic [31:0] w, input string tag);
    instr = w;
    mem_ready = 1'b1;
    @(negedge clk);
    total++;
    if (strb !== V_FETCH) begin
      bad++; $display("FAIL %s_fetch strb got=%b exp=%b", tag, strb, V_FETCH);
    end
    step();
    mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (strb !== V_IDLE) begin
      bad++; $display("FAIL %s_decode strb got=%b exp=%b", tag, strb, V_IDLE);
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; instr = 32'h0; z_flag = 1'b0; mem_ready = 1'b0;
    step(); step();
    @(negedge clk);
    total++;
    if ({strb, alu_func, mem_timeout, illegal} !== {V_IDLE, F_ADDU, 2'b00}) begin
      bad++; $display("FAIL reset_state got=%b/%b/%b%b exp=%b/%b/00",
                      strb, alu_func, mem_timeout, illegal, V_IDLE, F_ADDU);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    fetch_decode(32'h8C220004, "rst_lw");
    @(negedge clk);
    step();
    @(negedge clk);
    total++;
    if (strb !== V_RD) begin
      bad++; $display("FAIL rst_memrd strb got=%b exp=%b", strb, V_RD);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      total++;
      if ({strb, alu_func} !== {V_IDLE, F_ADDU}) begin
        bad++; $display("FAIL rst_hold%0d got=%b/%b exp=%b/%b", i, strb, alu_func, V_IDLE, F_ADDU);
      end
    end
    reset = 1'b0;
    #1;
    total++;
    if (strb !== V_RD) begin
      bad++; $display("FAIL rst_release_fetch strb got=%b exp=%b", strb, V_RD);
    end
    step();
  endtask

  task automatic test_add();
    fetch_decode(32'h00221820, "add");
    @(negedge clk);
    total++;
    if ({strb, alu_func} !== {V_IDLE, 6'b100000}) begin
      bad++; $display("FAIL add_exec got=%b/%b exp=%b/100000", strb, alu_func, V_IDLE);
    end
    step();
    @(negedge clk);
    total++;
    if (strb !== V_WB_R) begin
      bad++; $display("FAIL add_wb strb got=%b exp=%b", strb, V_WB_R);
    end
    step();
  endtask

  task automatic test_imm();
    logic [31:0] words [3];
    logic [5:0]  funcs [3];
    words = '{32'h20220005, 32'h3422000F, 32'h2C220001};
    funcs = '{6'b100000, 6'b100101, 6'b101011};
    for (int i = 0; i < 3; i++) begin
      fetch_decode(words[i], "imm");
      @(negedge clk);
      total++;
      if ({strb, alu_func} !== {V_IMM, funcs[i]}) begin
        bad++; $display("FAIL imm%0d_exec got=%b/%b exp=%b/%b", i, strb, alu_func, V_IMM, funcs[i]);
      end
      step();
      @(negedge clk);
      total++;
      if (strb !== V_WB_I) begin
        bad++; $display("FAIL imm%0d_wb strb got=%b exp=%b", i, strb, V_WB_I);
      end
      step();
    end
  endtask

  task automatic test_lw_wait();
    fetch_decode(32'h8C220004, "lw");
    @(negedge clk);
    total++;
    if ({strb, alu_func} !== {V_IMM, F_ADDU}) begin
      bad++; $display("FAIL lw_addr got=%b/%b exp=%b/%b", strb, alu_func, V_IMM, F_ADDU);
    end
    step();
    for (int i = 0; i < 6; i++) begin
      mem_ready = (i == 5);
      @(negedge clk);
      total++;
      if (strb !== V_RD) begin
        bad++; $display("FAIL lw_rd%0d strb got=%b exp=%b", i, strb, V_RD);
      end
      step();
    end
    mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({strb, mem_timeout} !== {V_WB_MEM, 1'b0}) begin
      bad++; $display("FAIL lw_wb got=%b/%b exp=%b/0", strb, mem_timeout, V_WB_MEM);
    end
    step();
  endtask

  task automatic sw_access(input int stalls, input logic ready_last, input string tag);
    fetch_decode(32'hAC220004, tag);
    @(negedge clk);
    total++;
    if (strb !== V_IMM) begin
      bad++; $display("FAIL %s_addr strb got=%b exp=%b", tag, strb, V_IMM);
    end
    step();
    for (int i = 0; i < stalls; i++) begin
      mem_ready = ready_last && (i == stalls - 1);
      @(negedge clk);
      total++;
      if ({strb, mem_timeout} !== {V_WR, 1'b0}) begin
        bad++; $display("FAIL %s_wr%0d got=%b/%b exp=%b/0", tag, i, strb, mem_timeout, V_WR);
      end
      step();
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_limit_ready();
    sw_access(15, 1'b1, "sw_edge");
    @(negedge clk);
    total++;
    if ({strb, mem_timeout} !== {V_RD, 1'b0}) begin
      bad++; $display("FAIL sw_edge_done got=%b/%b exp=%b/0", strb, mem_timeout, V_RD);
    end
    step();
  endtask

  task automatic test_sw_timeout();
    sw_access(15, 1'b0, "sw_to");
    @(negedge clk);
    total++;
    if ({strb, mem_timeout} !== {V_RD, 1'b1}) begin
      bad++; $display("FAIL sw_timeout got=%b/%b exp=%b/1", strb, mem_timeout, V_RD);
    end
    step();
  endtask

  task automatic test_branch();
    logic [31:0] words [5];
    logic        zs    [5];
    logic [9:0]  exps  [5];
    logic [5:0]  funcs [5];
    words = '{32'h10220003, 32'h14220003, 32'h14220003, 32'h18200002, 32'h1C200002};
    zs    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exps  = '{V_BR_T, V_IDLE, V_BR_T, V_IDLE, V_BR_T};
    funcs = '{6'b100010, 6'b100010, 6'b100010, 6'b110110, 6'b110010};
    for (int i = 0; i < 5; i++) begin
      fetch_decode(words[i], "br");
      z_flag = zs[i];
      @(negedge clk);
      total++;
      if ({strb, alu_func} !== {exps[i], funcs[i]}) begin
        bad++; $display("FAIL br%0d got=%b/%b exp=%b/%b", i, strb, alu_func, exps[i], funcs[i]);
      end
      step();
      z_flag = 1'b0;
    end
  endtask

  task automatic test_jump();
    fetch_decode(32'h08000010, "j");
    @(negedge clk);
    total++;
    if (strb !== V_JMP) begin
      bad++; $display("FAIL jump strb got=%b exp=%b", strb, V_JMP);
    end
    step();
  endtask

  task automatic test_illegal();
    fetch_decode(32'hFC000000, "ill_op");
`ifdef CTRL_ILLEGAL_TRAP_EN
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({strb, illegal} !== {V_IDLE, 1'b1}) begin
        bad++; $display("FAIL trap%0d got=%b/%b exp=%b/1", i, strb, illegal, V_IDLE);
      end
      step();
    end
    mem_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({strb, illegal} !== {V_RD, 1'b0}) begin
      bad++; $display("FAIL trap_reset got=%b/%b exp=%b/0", strb, illegal, V_RD);
    end
    step();
`else
    @(negedge clk);
    total++;
    if (illegal !== 1'b0) begin
      bad++; $display("FAIL ill_op_flag got=%b exp=0", illegal);
    end
    step();
    fetch_decode(32'h0000003F, "ill_fn");
`endif
    test_add();
  endtask

  initial begin
    test_reset();
    test_reset_mid_access();
    test_add();
    test_imm();
    test_lw_wait();
    test_limit_ready();
    test_sw_timeout();
    test_branch();
    test_jump();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
